// File: rtl/pwm_led_pkg.sv
// pwm_led_pkg: shared fade FSM state type and channel-index width helper
// for the multi-channel PWM LED driver.
package pwm_led_pkg;

    typedef enum logic {FADE_IDLE, FADE_RAMP} fade_state_e;

    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_led_channel.sv
// pwm_led_channel: one PWM output with target/current/active duty registers,
// a linear fade FSM and the period comparator.
module pwm_led_channel import pwm_led_pkg::*; #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             wrap,
    input  logic             fstep,
    input  logic [WIDTH-1:0] cmp,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_duty,
    input  logic             wr_fade,
    output logic             pwm_out,
    output logic             busy
);

    fade_state_e      state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] cur_q, cur_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic             pwm_q, pwm_d;
    logic [WIDTH-1:0] cur_step;

    assign cur_step = (target_q > cur_q) ? cur_q + WIDTH'(1) : cur_q - WIDTH'(1);

    // active only follows cur on the wrap so a period is never split
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        cur_d    = cur_q;
        active_d = wrap ? cur_q : active_q;
        pwm_d    = ena ? (cmp < active_q) : pwm_q;
        if (wr_en) begin
            target_d = wr_duty;
            cur_d    = wr_fade ? cur_q : wr_duty;
            state_d  = (wr_fade && wr_duty != cur_q) ? FADE_RAMP : FADE_IDLE;
        end else if (state_q == FADE_RAMP && fstep) begin
            cur_d   = cur_step;
            state_d = (cur_step == target_q) ? FADE_IDLE : FADE_RAMP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FADE_IDLE;
            target_q <= '0;
            cur_q    <= '0;
            active_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            cur_q    <= cur_d;
            active_q <= active_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;
    assign busy    = (state_q == FADE_RAMP);

endmodule

// File: rtl/pwm_led_multi.sv
// pwm_led_multi: multi-channel PWM LED driver with shared prescaled counter and
// per-channel fade engine. Define PWM_LED_PHASE_EN to stagger channel phases.
module pwm_led_multi import pwm_led_pkg::*; #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int PRESC_W  = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ena,
    input  logic [PRESC_W-1:0]                prescale,
    input  logic [PRESC_W-1:0]                fade_div,
    input  logic                              wr_valid,
    output logic                              wr_ready,
    input  logic [ch_idx_w(CHANNELS)-1:0]     wr_ch,
    input  logic [WIDTH-1:0]                  wr_duty,
    input  logic                              wr_fade,
    output logic [CHANNELS-1:0]               pwm_out,
    output logic [CHANNELS-1:0]               busy,
    output logic                              period_tick
);

    logic [PRESC_W-1:0] pc_q, pc_d;
    logic [PRESC_W-1:0] fdiv_q, fdiv_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic               pt_q, pt_d;
    logic               tick, wrap, fstep;

    assign tick     = ena && (pc_q == prescale);
    assign wrap     = tick && (&cnt_q);
    assign fstep    = wrap && (fdiv_q == fade_div);
    assign wr_ready = ~rst;

    always_comb begin
        pc_d   = ena ? (tick ? '0 : pc_q + PRESC_W'(1)) : pc_q;
        cnt_d  = tick ? cnt_q + WIDTH'(1) : cnt_q;
        fdiv_d = wrap ? (fstep ? '0 : fdiv_q + PRESC_W'(1)) : fdiv_q;
        pt_d   = wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= '0;
            cnt_q  <= '0;
            fdiv_q <= '0;
            pt_q   <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            cnt_q  <= cnt_d;
            fdiv_q <= fdiv_d;
            pt_q   <= pt_d;
        end
    end

    assign period_tick = pt_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] cmp;
`ifdef PWM_LED_PHASE_EN
        assign cmp = cnt_q + WIDTH'(i * ((1 << WIDTH) / CHANNELS));
`else
        assign cmp = cnt_q;
`endif
        pwm_led_channel #(.WIDTH(WIDTH)) u_ch (
            .clk     (clk),
            .rst     (rst),
            .ena     (ena),
            .wrap    (wrap),
            .fstep   (fstep),
            .cmp     (cmp),
            .wr_en   (wr_valid && (32'(wr_ch) == i)),
            .wr_duty (wr_duty),
            .wr_fade (wr_fade),
            .pwm_out (pwm_out[i]),
            .busy    (busy[i])
        );
    end

endmodule

// File: tb/tb_pwm_led_multi.sv
// tb_pwm_led_multi: randomized and directed checks of pwm_led_multi against an
// arithmetic reference model; honours PWM_LED_PHASE_EN like the design.
module tb_pwm_led_multi;

    localparam int CH = 4;
`ifdef PWM_LED_PHASE_EN
    localparam int PH = 64;
`else
    localparam int PH = 0;
`endif

    logic       clk = 0, rst = 0, ena = 0;
    logic [7:0] prescale = 0, fade_div = 0;
    logic       wr_valid = 0, wr_fade = 0;
    logic [1:0] wr_ch = 0;
    logic [7:0] wr_duty = 0;
    logic       wr_ready, period_tick;
    logic [3:0] pwm_out, busy;
    int         tests = 0, fails = 0;

    always #5 clk = ~clk;

    pwm_led_multi #(.CHANNELS(4), .WIDTH(8), .PRESC_W(8)) dut (
        .clk(clk), .rst(rst), .ena(ena), .prescale(prescale), .fade_div(fade_div),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ch(wr_ch), .wr_duty(wr_duty),
        .wr_fade(wr_fade), .pwm_out(pwm_out), .busy(busy), .period_tick(period_tick)
    );

    // model: counter position derived from the number of enabled clocks
    int         en_clk, wraps, mp, mfd;
    int         tgt[CH], cur[CH], act[CH];
    bit         ramp[CH];
    logic [3:0] m_pwm, m_busy;
    logic       m_pt;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic model_clear(input int p, input int fd);
        en_clk = 0; wraps = 0; mp = p; mfd = fd;
        m_pwm = 0; m_busy = 0; m_pt = 0;
        for (int i = 0; i < CH; i++) begin
            tgt[i] = 0; cur[i] = 0; act[i] = 0; ramp[i] = 0;
        end
    endtask

    task automatic model_update();
        int c;
        bit tick, wrap, fstep;
        c     = (en_clk / (mp + 1)) % 256;
        tick  = ena && (en_clk % (mp + 1) == mp);
        wrap  = tick && c == 255;
        for (int i = 0; i < CH; i++)
            if (ena) m_pwm[i] = ((c + PH * i) % 256) < act[i];
        m_pt = wrap;
        if (ena) en_clk++;
        if (wrap) wraps++;
        fstep = wrap && (wraps % (mfd + 1) == 0);
        for (int i = 0; i < CH; i++) begin
            if (wrap) act[i] = cur[i];
            if (wr_valid && int'(wr_ch) == i) begin
                tgt[i] = wr_duty;
                if (!wr_fade) cur[i] = wr_duty;
                ramp[i] = wr_fade && (tgt[i] != cur[i]);
            end else if (ramp[i] && fstep) begin
                cur[i] += (tgt[i] > cur[i]) ? 1 : -1;
                ramp[i] = cur[i] != tgt[i];
            end
            m_busy[i] = ramp[i];
        end
    endtask

    task automatic cyc();
        model_update();
        @(posedge clk);
        @(negedge clk);
        chk("cycle_outputs", {pwm_out, busy, period_tick, wr_ready}, {m_pwm, m_busy, m_pt, 1'b1});
    endtask

    task automatic do_reset(input int p, input int fd);
        #2 rst = 1;
        #1 chk("async_reset_outputs", {pwm_out, busy, period_tick, wr_ready}, 0);
        prescale = 8'(p); fade_div = 8'(fd); wr_valid = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_clear(p, fd);
    endtask

    task automatic wr(input int ch, input int d, input bit f);
        wr_valid = 1; wr_ch = 2'(ch); wr_duty = 8'(d); wr_fade = f;
        cyc();
        wr_valid = 0;
    endtask

    task automatic next_pt(output int n);
        n = 0;
        do begin cyc(); n++; end while (period_tick !== 1'b1 && n < 5000);
        if (period_tick !== 1'b1) chk("period_tick_timeout", 0, 1);
    endtask

    task automatic window(input int ch, output int hi, output int len);
        hi = 0; len = 0;
        do begin cyc(); len++; hi += int'(pwm_out[ch]); end while (period_tick !== 1'b1 && len < 5000);
        if (period_tick !== 1'b1) chk("window_timeout", 0, 1);
    endtask

    initial begin
        int hi, len, n;
        int up[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 4};
        int dn[4] = '{5, 4, 3, 2};
        int rise[CH];
        logic [3:0] prev;

        do_reset(0, 0); ena = 1;
        wr(0, 128, 0);
        next_pt(n);
        window(0, hi, len); chk("duty128_high", hi, 128);
        repeat (50) cyc();
        chk("pwm_high_before_reset", pwm_out[0], 1);
        do_reset(0, 0);
        next_pt(n); chk("first_period_after_reset", n, 256);
        window(0, hi, len); chk("low_after_reset", hi, 0); chk("period_256", len, 256);

        wr(0, 64, 0); next_pt(n);
        window(0, hi, len); chk("duty64_high", hi, 64); chk("duty64_period", len, 256);
        wr(0, 0, 0); next_pt(n);
        window(0, hi, len); chk("duty0_high", hi, 0);
        wr(0, 255, 0); next_pt(n);
        window(0, hi, len); chk("duty255_high", hi, 255);
        do_reset(3, 0); ena = 1;
        next_pt(n); window(0, hi, len); chk("prescale3_period", len, 1024);

        do_reset(0, 1); ena = 1;
        wr(1, 4, 1);
        chk("fade_busy_rise", busy[1], 1);
        next_pt(n);
        for (int k = 0; k < 9; k++) begin
            window(1, hi, len);
            chk($sformatf("fade_up_%0d", k), hi, up[k]);
            if (k == 5) chk("fade_busy_before_last", busy[1], 1);
            if (k == 6) chk("fade_busy_fall", busy[1], 0);
        end

        do_reset(0, 0); ena = 1;
        wr(2, 10, 1);
        repeat (5) next_pt(n);
        wr(2, 2, 1);
        next_pt(n);
        for (int k = 0; k < 4; k++) begin
            window(2, hi, len);
            chk($sformatf("retarget_%0d", k), hi, dn[k]);
        end
        chk("retarget_busy_done", busy[2], 0);

        wr(3, 50, 1);
        next_pt(n);
        repeat (255) cyc();
        wr(3, 20, 0);
        chk("collide_on_wrap", period_tick, 1);
        window(3, hi, len); chk("collide_pre", hi, 1);
        window(3, hi, len); chk("collide_write_wins", hi, 20);
        chk("collide_not_busy", busy[3], 0);

        do_reset(0, 0); ena = 1;
        wr(0, 64, 0); next_pt(n);
        repeat (30) cyc();
        ena = 0;
        wr(0, 100, 0);
        repeat (99) cyc();
        chk("freeze_hold_high", pwm_out[0], 1);
        ena = 1;
        next_pt(n); chk("freeze_no_lost_counts", n + 130, 356);
        window(0, hi, len); chk("freeze_write_applied", hi, 100);

        do_reset(0, 0); ena = 1;
        for (int i = 0; i < CH; i++) wr(i, 64, 0);
        next_pt(n); next_pt(n);
        prev = pwm_out;
        for (int i = 0; i < CH; i++) rise[i] = -1;
        for (int k = 1; k <= 256; k++) begin
            cyc();
            for (int i = 0; i < CH; i++)
                if (rise[i] < 0 && pwm_out[i] && !prev[i]) rise[i] = k;
            prev = pwm_out;
        end
        for (int i = 0; i < CH; i++)
            chk($sformatf("rise_ch%0d", i), rise[i], 1 + (256 - PH * i) % 256);

        for (int r = 0; r < 3; r++) begin
            do_reset($urandom_range(0, 1), $urandom_range(0, 2));
            repeat (4000) begin
                ena      = ($urandom_range(0, 15) != 0);
                wr_valid = ($urandom_range(0, 19) == 0);
                wr_ch    = 2'($urandom);
                wr_duty  = $urandom_range(0, 1) ? 8'($urandom_range(0, 12)) : 8'($urandom);
                wr_fade  = 1'($urandom);
                cyc();
            end
            wr_valid = 0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
